// File: rtl/mainmemory_pipe.sv
// Line-granular main memory: pipelined reads, throttled byte-masked writes.
// Define MAINMEMORY_PIPE_STATS_EN to add request/stall statistics outputs.
module mainmemory_pipe #(
    parameter int LINE_BITS       = 256,
    parameter int ADDR_BITS       = 27,
    parameter int ENTRIES         = 32768,
    parameter int READ_LAT        = 4,
    parameter int WRITE_TPUT      = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [ADDR_BITS-1:0]   a,
    input  logic [LINE_BITS/8-1:0] be,
    input  logic [LINE_BITS-1:0]   wd,
    input  logic                   read,
    input  logic                   write,
    output logic                   ready,
    output logic [LINE_BITS-1:0]   rd,
    output logic                   valid,
    output logic                   req_err
`ifdef MAINMEMORY_PIPE_STATS_EN
    ,
    output logic [31:0]            stat_rd,
    output logic [31:0]            stat_wr,
    output logic [31:0]            stat_stall
`endif
);

    localparam int NB = LINE_BITS / 8;
    localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int BW = (WRITE_TPUT > 1) ? $clog2(WRITE_TPUT) : 1;
    localparam logic [BW-1:0] BUSY_LOAD = BW'(WRITE_TPUT - 1);
    localparam logic [OW-1:0] OS_MAX = OW'(MAX_OUTSTANDING);

    logic [LINE_BITS-1:0] mem [ENTRIES];
    logic [LINE_BITS-1:0] pd_q [READ_LAT];
    logic [READ_LAT-1:0]  pv_q;
    logic [OW-1:0]        os_q;
    logic [BW-1:0]        busy_q;
    logic                 run_q;
    logic                 valid_q;
    logic                 err_q;
    logic [LINE_BITS-1:0] rd_q;
    logic [IW-1:0]        idx;
    logic                 retire;
    logic                 wr_acc;
    logic                 rd_acc;
    logic                 both_acc;

    assign idx = a[IW-1:0];

    generate
        if (ADDR_BITS > IW) begin : g_addr_hi
            logic unused_hi;
            assign unused_hi = ^a[ADDR_BITS-1:IW];
        end
    endgenerate

    // A read retiring this cycle frees its slot for a same-cycle accept.
    assign retire   = pv_q[READ_LAT-1];
    assign ready    = run_q & (busy_q == '0) & ((os_q < OS_MAX) | retire);
    assign wr_acc   = write & ready;
    assign rd_acc   = read & ~write & ready;
    assign both_acc = read & write & ready;

    always_ff @(posedge clk) begin
        pd_q[0] <= mem[idx];
        for (int i = 1; i < READ_LAT; i++) begin
            pd_q[i] <= pd_q[i-1];
        end
        if (wr_acc) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem[idx][b*8 +: 8] <= wd[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pv_q    <= '0;
            os_q    <= '0;
            busy_q  <= '0;
            run_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= '0;
        end else begin
            run_q   <= 1'b1;
            pv_q[0] <= rd_acc;
            for (int i = 1; i < READ_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
            end
            valid_q <= retire;
            if (retire) begin
                rd_q <= pd_q[READ_LAT-1];
            end
            err_q <= both_acc;
            os_q  <= os_q + OW'(rd_acc) - OW'(retire);
            if (wr_acc) begin
                busy_q <= BUSY_LOAD;
            end else if (busy_q != '0) begin
                busy_q <= busy_q - 1'b1;
            end
        end
    end

    assign valid   = valid_q;
    assign rd      = rd_q;
    assign req_err = err_q;

`ifdef MAINMEMORY_PIPE_STATS_EN
    logic [31:0] st_rd_q;
    logic [31:0] st_wr_q;
    logic [31:0] st_stall_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_rd_q    <= '0;
            st_wr_q    <= '0;
            st_stall_q <= '0;
        end else begin
            if (rd_acc && st_rd_q != '1) begin
                st_rd_q <= st_rd_q + 32'd1;
            end
            if (wr_acc && st_wr_q != '1) begin
                st_wr_q <= st_wr_q + 32'd1;
            end
            if ((read | write) && !ready && st_stall_q != '1) begin
                st_stall_q <= st_stall_q + 32'd1;
            end
        end
    end

    assign stat_rd    = st_rd_q;
    assign stat_wr    = st_wr_q;
    assign stat_stall = st_stall_q;
`endif

endmodule
